// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: opcode values, format codes, instruction field positions
// and the opcode-to-format classifier used by the decode stage.
package riscv_pkg;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned RD_LSB     = 7;
    localparam int unsigned FUNCT3_LSB = 12;
    localparam int unsigned RS1_LSB    = 15;
    localparam int unsigned RS2_LSB    = 20;
    localparam int unsigned FUNCT7_LSB = 25;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    // The *-32 opcodes only exist on RV64; on RV32 they decode as illegal.
    function automatic fmt_e classify(input logic [31:0] instr, input logic rv64);
        fmt_e f;
        f = FMT_ILL;
        if (instr[1:0] == 2'b11) begin
            case (instr[6:0])
                OPC_LUI, OPC_AUIPC:                  f = FMT_U;
                OPC_JAL:                             f = FMT_J;
                OPC_BRANCH:                          f = FMT_B;
                OPC_STORE:                           f = FMT_S;
                OPC_JALR, OPC_LOAD, OPC_OP_IMM,
                OPC_MISC_MEM, OPC_SYSTEM:            f = FMT_I;
                OPC_OP_IMM_32:                       f = rv64 ? FMT_I : FMT_ILL;
                OPC_OP:                              f = FMT_R;
                OPC_OP_32:                           f = rv64 ? FMT_R : FMT_ILL;
                default:                             f = FMT_ILL;
            endcase
        end
        return f;
    endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Immediate generator: assembles the format-specific immediate and sign-extends it to XLEN.
module rv_imm_gen
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr,
    input  fmt_e            fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm32 = {instr[31:12], 12'b0};
            FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        imm = XLEN'($signed(imm32));
    end

endmodule

// File: rtl/decode_stage.sv
// Registered, handshaked RV32/RV64 decode stage. Decode happens on the input side and the
// decoded bundle is registered; an optional skid register keeps in_ready registered.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            illegal;
    } bundle_t;

    fmt_e            in_fmt;
    logic [XLEN-1:0] in_imm;
    bundle_t         in_bundle;

    logic    out_valid_q, out_valid_d;
    bundle_t out_q, out_d;

    always_comb begin
        in_fmt = classify(in_instr, XLEN == 64);
    end

    rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (in_instr),
        .fmt   (in_fmt),
        .imm   (in_imm)
    );

    always_comb begin
        in_bundle.pc      = in_pc;
        in_bundle.instr   = in_instr;
        in_bundle.imm     = in_imm;
        in_bundle.fmt     = in_fmt;
        in_bundle.illegal = (in_fmt == FMT_ILL);
    end

    generate
        if (SKID_EN) begin : g_skid
            logic    skid_valid_q, skid_valid_d;
            bundle_t skid_q, skid_d;

            // in_ready only looks at registered state, so upstream never sees out_ready.
            always_comb begin
                in_ready     = !rst && !skid_valid_q;
                out_valid_d  = out_valid_q;
                out_d        = out_q;
                skid_valid_d = skid_valid_q;
                skid_d       = skid_q;
                if (flush) begin
                    out_valid_d  = 1'b0;
                    skid_valid_d = 1'b0;
                end else if (!out_valid_q || out_ready) begin
                    if (skid_valid_q) begin
                        out_valid_d  = 1'b1;
                        out_d        = skid_q;
                        skid_valid_d = 1'b0;
                    end else if (in_valid && in_ready) begin
                        out_valid_d = 1'b1;
                        out_d       = in_bundle;
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end else if (in_valid && in_ready) begin
                    skid_valid_d = 1'b1;
                    skid_d       = in_bundle;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    skid_valid_q <= 1'b0;
                    skid_q       <= '0;
                end else begin
                    skid_valid_q <= skid_valid_d;
                    skid_q       <= skid_d;
                end
            end
        end else begin : g_single
            always_comb begin
                in_ready    = !rst && (!out_valid_q || out_ready);
                out_valid_d = out_valid_q;
                out_d       = out_q;
                if (flush) begin
                    out_valid_d = 1'b0;
                end else if (in_valid && in_ready) begin
                    out_valid_d = 1'b1;
                    out_d       = in_bundle;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    always_comb begin
        out_valid = out_valid_q;
        out_pc    = out_q.pc;
        opcode    = out_q.instr[OPCODE_LSB +: 7];
        rd        = out_q.instr[RD_LSB +: 5];
        funct3    = out_q.instr[FUNCT3_LSB +: 3];
        rs1       = out_q.instr[RS1_LSB +: 5];
        rs2       = out_q.instr[RS2_LSB +: 5];
        funct7    = out_q.instr[FUNCT7_LSB +: 7];
        imm       = out_q.imm;
        fmt       = out_q.fmt;
        illegal   = out_q.illegal;
    end

endmodule
